// File: rtl/tiny_eth_rx_framer.sv
// tiny_eth_rx_framer: receive framing stage between tiny_eth_phy and tiny_eth_mac.
// It takes the MII nibble stream, strips the preamble and SFD, and packs bytes low nibble first.
// Bytes leave as a valid-only stream with SOF/EOF markers, the frame length and error flags.
// A one-byte hold register delays each byte, so that EOF can be flagged on the last byte.
// Optional feature: define TINY_ETH_RX_CRC_EN to add the CRC-32 FCS residue check.
// When it is undefined, crc_err is always 0.
module tiny_eth_rx_framer #(
    parameter int unsigned MIN_PRE = 6,
    parameter int unsigned MAX_LEN = 1518,
    parameter int unsigned LEN_W   = 11
) (
    input  logic             rx_clk,
    input  logic             rst,
    input  logic [3:0]       rx_data,
    input  logic             rx_dv,
    input  logic             rx_er,
    output logic [7:0]       out_data,
    output logic             out_valid,
    output logic             out_sof,
    output logic             out_eof,
    output logic             out_err,
    output logic [LEN_W-1:0] frame_len,
    output logic             crc_err
);

    typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_DROP} state_e;

    state_e           state_q, state_d;
    logic [3:0]       pre_cnt_q, pre_cnt_d;
    logic             phase_q, phase_d;
    logic [3:0]       lo_q, lo_d;
    logic [7:0]       hold_q, hold_d;
    logic             hold_vld_q, hold_vld_d;
    logic             first_q, first_d;
    logic             err_q, err_d;
    logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             sof_q, sof_d;
    logic             eof_q, eof_d;
    logic             oerr_q, oerr_d;
    logic             crc_err_q, crc_err_d;

    logic             emit;
    logic             emit_eof;
    logic             emit_err;
    logic [7:0]       byte_new;
    logic             crc_bad;

    assign byte_new = {rx_data, lo_q};

`ifdef TINY_ETH_RX_CRC_EN
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    logic [31:0] crc_q, crc_d;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int unsigned i = 0; i < 8; i++) begin
            if (r[0] ^ b[i]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    // CRC runs over every completed byte of the frame and is re-seeded whenever we are outside DATA
    always_comb begin
        crc_d = crc_q;
        if (state_q != S_DATA)       crc_d = '1;
        else if (rx_dv && phase_q)   crc_d = crc_byte(crc_q, byte_new);
    end

    // CRC register
    always_ff @(posedge rx_clk or negedge rst) begin
        if (!rst) crc_q <= '1;
        else      crc_q <= crc_d;
    end

    assign crc_bad = (crc_q != CRC_RESIDUE);
`else
    assign crc_bad = 1'b0;
`endif

    // Next-state, hold-register and output-strobe logic
    always_comb begin
        state_d    = state_q;
        pre_cnt_d  = pre_cnt_q;
        phase_d    = phase_q;
        lo_d       = lo_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        first_d    = first_q;
        err_d      = err_q;
        byte_cnt_d = byte_cnt_q;
        len_d      = len_q;
        data_d     = '0;
        valid_d    = 1'b0;
        sof_d      = 1'b0;
        eof_d      = 1'b0;
        oerr_d     = 1'b0;
        crc_err_d  = 1'b0;
        emit       = 1'b0;
        emit_eof   = 1'b0;
        emit_err   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (rx_dv) begin
                    if (rx_data == 4'h5) begin
                        state_d   = S_PRE;
                        pre_cnt_d = 4'd1;
                    end else begin
                        state_d = S_DROP;
                    end
                end
            end
            S_PRE: begin
                if (!rx_dv) begin
                    state_d = S_IDLE;
                end else if (rx_data == 4'h5) begin
                    if (pre_cnt_q != 4'hF) pre_cnt_d = pre_cnt_q + 4'd1;
                end else if (rx_data == 4'hD && int'(unsigned'(pre_cnt_q)) >= int'(MIN_PRE)) begin
                    state_d    = S_DATA;
                    phase_d    = 1'b0;
                    hold_vld_d = 1'b0;
                    first_d    = 1'b1;
                    err_d      = 1'b0;
                    byte_cnt_d = '0;
                end else begin
                    state_d = S_DROP;
                end
            end
            S_DATA: begin
                if (rx_dv) begin
                    if (rx_er) err_d = 1'b1;
                    if (!phase_q) begin
                        lo_d    = rx_data;
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (byte_cnt_q == LEN_W'(MAX_LEN)) begin
                            // Byte MAX_LEN+1 is never emitted: the held byte closes the frame as bad
                            emit       = hold_vld_q;
                            emit_eof   = 1'b1;
                            emit_err   = 1'b1;
                            hold_vld_d = 1'b0;
                            state_d    = S_DROP;
                        end else begin
                            emit       = hold_vld_q;
                            hold_d     = byte_new;
                            hold_vld_d = 1'b1;
                            byte_cnt_d = byte_cnt_q + LEN_W'(1);
                        end
                    end
                end else begin
                    // rx_dv fell: flush the held byte as EOF; a runt with no complete byte vanishes
                    emit       = hold_vld_q;
                    emit_eof   = 1'b1;
                    emit_err   = err_q | phase_q | crc_bad;
                    hold_vld_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            S_DROP: begin
                if (!rx_dv) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (emit) begin
            valid_d   = 1'b1;
            data_d    = hold_q;
            sof_d     = first_q;
            eof_d     = emit_eof;
            oerr_d    = emit_eof & emit_err;
            crc_err_d = emit_eof & crc_bad;
            first_d   = 1'b0;
            len_d     = first_q ? LEN_W'(1) : len_q + LEN_W'(1);
        end
    end

    // State, counters, hold register and registered outputs
    always_ff @(posedge rx_clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            pre_cnt_q  <= '0;
            phase_q    <= 1'b0;
            lo_q       <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            first_q    <= 1'b0;
            err_q      <= 1'b0;
            byte_cnt_q <= '0;
            len_q      <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            sof_q      <= 1'b0;
            eof_q      <= 1'b0;
            oerr_q     <= 1'b0;
            crc_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_cnt_q  <= pre_cnt_d;
            phase_q    <= phase_d;
            lo_q       <= lo_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            first_q    <= first_d;
            err_q      <= err_d;
            byte_cnt_q <= byte_cnt_d;
            len_q      <= len_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            sof_q      <= sof_d;
            eof_q      <= eof_d;
            oerr_q     <= oerr_d;
            crc_err_q  <= crc_err_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_sof   = sof_q;
    assign out_eof   = eof_q;
    assign out_err   = oerr_q;
    assign frame_len = len_q;
    assign crc_err   = crc_err_q;

endmodule
